imem_prog: RTL

IMEM_PROG -- requirements
Module: imem_prog

---
 rtl/imem_prog.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - loadable instruction memory with LOAD/RUN modes and a one-cycle registered fetch port
module imem_prog #(
    parameter int INSTR_W = 18,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ready,
    output logic [ADDR_W:0]    ld_count,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               fetch_en,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    ld_count_q, ld_count_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               addr_err_q, addr_err_d;
    logic               mem_we;
    logic               ld_in_range;
    logic               pc_in_range;

    logic [INSTR_W-1:0] mem [DEPTH];

    assign ld_in_range = {1'b0, ld_addr} < DEPTH_C;
    assign pc_in_range = {1'b0, pc} < DEPTH_C;

    always_comb begin
        state_d       = state_q;
        ld_count_d    = ld_count_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        addr_err_d    = addr_err_q;
        mem_we        = 1'b0;
        case (state_q)
            S_LOAD: begin
                instr_d       = NOP_WORD;
                instr_valid_d = 1'b0;
                addr_err_d    = 1'b0;
                if (ld_start) begin
                    ld_count_d = '0;
                end else if (ld_en) begin
                    if (ld_in_range) begin
                        mem_we = 1'b1;
                        if (ld_count_q != DEPTH_C) begin
                            ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
                        end
                    end
                    // ld_last returns to RUN even when the word itself was dropped
                    if (ld_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ld_start) begin
                    state_d       = S_LOAD;
                    ld_count_d    = '0;
                    instr_d       = NOP_WORD;
                    instr_valid_d = 1'b0;
                    addr_err_d    = 1'b0;
                end else if (fetch_en) begin
                    if (pc_in_range) begin
                        instr_d       = mem[pc[IDX_W-1:0]];
                        instr_valid_d = 1'b1;
                        addr_err_d    = 1'b0;
                    end else begin
                        instr_d       = NOP_WORD;
                        instr_valid_d = 1'b0;
                        addr_err_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            ld_count_q    <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_count_q    <= ld_count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Contents are deliberately not reset so a program survives rst
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

    assign ready       = (state_q == S_RUN);
    assign ld_count    = ld_count_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;

endmodule
